// File: rtl/dpd_actuator_v3.sv
// Multi-lane DPD actuator: per-lane complex gain from a double-banked LUT,
// Q2.14 rounding/saturation, runtime output mode and glitch-free bank swap.
module dpd_actuator_v3 #(
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned SWAP_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tu_enable,
  input  logic [NUM_LANES*32-1:0]         tu,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] mag,
  input  logic [1:0]                      mode,
  input  logic                            cfg_en,
  input  logic                            cfg_we,
  input  logic [ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [31:0]                     cfg_din,
  output logic [31:0]                     cfg_dout,
  output logic                            cfg_valid,
  input  logic                            cfg_swap,
  output logic [NUM_LANES*32-1:0]         tx,
  output logic                            tx_valid,
  output logic                            active_bank,
  output logic                            swap_pending,
  output logic [15:0]                     swap_count,
  output logic                            sat_event
);

  localparam int unsigned LANE_W  = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned PROD_W  = 32;
  localparam int unsigned ACC_W   = 34;
  localparam int unsigned FRAC_W  = 14;
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned BUS_W   = NUM_LANES * LANE_W;
  localparam int unsigned TIMER_W = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {
    MODE_DPD    = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_ZERO   = 2'd2,
    MODE_HOLD   = 2'd3
  } out_mode_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_t;

  // Signed 16x16 product of two raw halfwords.
  function automatic logic signed [PROD_W-1:0] mul16(input logic [HALF_W-1:0] a,
                                                      input logic [HALF_W-1:0] b);
    return PROD_W'(signed'(a)) * PROD_W'(signed'(b));
  endfunction

  // Round-half-up, shift out Q2.14 fraction, clip to int16; bit 16 flags a clip.
  function automatic logic [HALF_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = (acc + RND) >>> FRAC_W;
    if (sh > SAT_MAX)      return {1'b1, 16'h7fff};
    else if (sh < SAT_MIN) return {1'b1, 16'h8000};
    else                   return {1'b0, sh[HALF_W-1:0]};
  endfunction

  // Both banks live in one array; the bank bit is the index MSB.
  logic [31:0] lut_mem [2*DEPTH];

  // ---------------------------------------------------------------------------
  // Config port: writes and reads always target the shadow bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_en && cfg_we) begin
      lut_mem[{~active_bank, cfg_addr}] <= cfg_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_dout  <= '0;
      cfg_valid <= 1'b0;
    end else begin
      cfg_valid <= cfg_en && !cfg_we;
      if (cfg_en && !cfg_we) begin
        cfg_dout <= lut_mem[{~active_bank, cfg_addr}];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------------
  swap_state_t        state_q, state_d;
  logic [TIMER_W-1:0] swap_timer;
  logic               timer_last_c;
  logic               swap_fire_c;
  logic               timer_clr_c;
  logic               timer_inc_c;

  assign timer_last_c = (swap_timer == TIMER_W'(SWAP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      swap_timer  <= '0;
      active_bank <= 1'b0;
      swap_count  <= '0;
    end else begin
      state_q <= state_d;
      if (timer_clr_c) begin
        swap_timer <= '0;
      end else if (timer_inc_c) begin
        swap_timer <= swap_timer + TIMER_W'(1);
      end
      if (swap_fire_c) begin
        active_bank <= ~active_bank;
        swap_count  <= swap_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg_swap) state_d = ST_PENDING;
      ST_PENDING: if (!tu_enable || timer_last_c) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A pending swap commits on the first idle beat or when the timer expires.
  always_comb begin
    swap_fire_c = 1'b0;
    timer_clr_c = 1'b0;
    timer_inc_c = 1'b0;
    case (state_q)
      ST_IDLE: timer_clr_c = cfg_swap;
      ST_PENDING: begin
        if (!tu_enable || timer_last_c) swap_fire_c = 1'b1;
        else                            timer_inc_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign swap_pending = (state_q == ST_PENDING);

  // ---------------------------------------------------------------------------
  // S1: capture samples and gains; the bank bit is the pre-swap value on a swap edge.
  // ---------------------------------------------------------------------------
  logic             en_s1;
  logic [BUS_W-1:0] tu_s1;
  logic [BUS_W-1:0] gain_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_s1   <= 1'b0;
      tu_s1   <= '0;
      gain_s1 <= '0;
    end else begin
      en_s1 <= tu_enable;
      tu_s1 <= tu;
      for (int k = 0; k < NUM_LANES; k++) begin
        gain_s1[LANE_W*k +: LANE_W] <= lut_mem[{active_bank, mag[ADDR_WIDTH*k +: ADDR_WIDTH]}];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: four partial products per lane
  // ---------------------------------------------------------------------------
  logic                     en_s2;
  logic [BUS_W-1:0]         tu_s2;
  logic signed [PROD_W-1:0] p_ii [NUM_LANES];
  logic signed [PROD_W-1:0] p_qq [NUM_LANES];
  logic signed [PROD_W-1:0] p_iq [NUM_LANES];
  logic signed [PROD_W-1:0] p_qi [NUM_LANES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_s2 <= 1'b0;
      tu_s2 <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        p_ii[k] <= '0;
        p_qq[k] <= '0;
        p_iq[k] <= '0;
        p_qi[k] <= '0;
      end
    end else begin
      en_s2 <= en_s1;
      tu_s2 <= tu_s1;
      for (int k = 0; k < NUM_LANES; k++) begin
        p_ii[k] <= mul16(tu_s1[LANE_W*k +: HALF_W],          gain_s1[LANE_W*k +: HALF_W]);
        p_qq[k] <= mul16(tu_s1[LANE_W*k + HALF_W +: HALF_W], gain_s1[LANE_W*k + HALF_W +: HALF_W]);
        p_iq[k] <= mul16(tu_s1[LANE_W*k +: HALF_W],          gain_s1[LANE_W*k + HALF_W +: HALF_W]);
        p_qi[k] <= mul16(tu_s1[LANE_W*k + HALF_W +: HALF_W], gain_s1[LANE_W*k +: HALF_W]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: complex combine, round/saturate, mode mux
  // ---------------------------------------------------------------------------
  logic [HALF_W:0]  r_i [NUM_LANES];
  logic [HALF_W:0]  r_q [NUM_LANES];
  logic [BUS_W-1:0] dpd_c;
  logic             clip_c;

  always_comb begin
    dpd_c  = '0;
    clip_c = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      r_i[k] = round_sat(ACC_W'(p_ii[k]) - ACC_W'(p_qq[k]));
      r_q[k] = round_sat(ACC_W'(p_iq[k]) + ACC_W'(p_qi[k]));
      dpd_c[LANE_W*k +: HALF_W]          = r_i[k][HALF_W-1:0];
      dpd_c[LANE_W*k + HALF_W +: HALF_W] = r_q[k][HALF_W-1:0];
      clip_c = clip_c | r_i[k][HALF_W] | r_q[k][HALF_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx        <= '0;
      tx_valid  <= 1'b0;
      sat_event <= 1'b0;
    end else begin
      tx_valid  <= en_s2;
      sat_event <= en_s2 && (mode == MODE_DPD) && clip_c;
      if (en_s2) begin
        case (mode)
          MODE_DPD:    tx <= dpd_c;
          MODE_BYPASS: tx <= tu_s2;
          MODE_ZERO:   tx <= '0;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpd_actuator_v3.sv
// Directed bench for dpd_actuator_v3: gain math, modes, saturation, swap timing,
// config collisions and reset behaviour against hand-computed values.
module tb_dpd_actuator_v3;

  localparam int unsigned NL = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned ST = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tu_enable;
  logic [NL*32-1:0]  tu;
  logic [NL*AW-1:0]  mag;
  logic [1:0]        mode;
  logic              cfg_en;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [31:0]       cfg_din;
  logic [31:0]       cfg_dout;
  logic              cfg_valid;
  logic              cfg_swap;
  logic [NL*32-1:0]  tx;
  logic              tx_valid;
  logic              active_bank;
  logic              swap_pending;
  logic [15:0]       swap_count;
  logic              sat_event;

  int checks = 0;
  int errors = 0;

  dpd_actuator_v3 #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .SWAP_TIMEOUT(ST)) dut (
    .clk(clk), .rst_n(rst_n), .tu_enable(tu_enable), .tu(tu), .mag(mag), .mode(mode),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_valid(cfg_valid), .cfg_swap(cfg_swap), .tx(tx),
    .tx_valid(tx_valid), .active_bank(active_bank), .swap_pending(swap_pending),
    .swap_count(swap_count), .sat_event(sat_event)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input int i, input int q);
    return {16'(q), 16'(i)};
  endfunction

  task automatic cfg_wr(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
    tick();
    cfg_en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    tick();
    check({tag, "_valid"}, cfg_valid, 1);
    check({tag, "_data"}, cfg_dout, exp);
    cfg_en = 1'b0;
    tick();
    check({tag, "_vdrop"}, cfg_valid, 0);
  endtask

  task automatic swap_idle();
    tu_enable = 1'b0; cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    tick();
  endtask

  // One-beat transaction; returns on the cycle its result appears on tx.
  task automatic beat(input string tag, input logic [NL*32-1:0] t, input logic [NL*AW-1:0] m);
    tu = t; mag = m; tu_enable = 1'b1;
    tick();
    tu_enable = 1'b0;
    tick();
    check({tag, "_early"}, tx_valid, 0);
    tick();
    check({tag, "_valid"}, tx_valid, 1);
  endtask

  logic [NL*32-1:0] tu1, tu2, tu3, tu4, tu5;

  initial begin
    rst_n = 1'b0; tu_enable = 1'b0; tu = '0; mag = '0; mode = 2'd0;
    cfg_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_din = '0; cfg_swap = 1'b0;
    tu1 = {lane(-32768, 7), lane(1000, -500)};
    tu2 = {lane(-2000, 400), lane(1000, -500)};
    tu3 = {lane(-32768, 0), lane(32767, 32767)};
    tu4 = {lane(100, -100), lane(-32768, 0)};
    tu5 = {lane(1000, -500), lane(1000, -500)};

    tick(); tick();
    check("rst_tx", tx, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_bank", active_bank, 0);
    check("rst_cnt", swap_count, 0);
    check("rst_pend", swap_pending, 0);
    check("rst_cfgv", cfg_valid, 0);
    check("rst_sat", sat_event, 0);
    rst_n = 1'b1;
    tick();

    // Unity gain in bank 1
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_din = 32'h0000_4000;
    for (int a = 0; a < (1 << AW); a++) begin
      cfg_addr = AW'(a);
      tick();
    end
    cfg_en = 1'b0; cfg_we = 1'b0;
    swap_idle();
    check("t1_bank", active_bank, 1);
    check("t1_cnt", swap_count, 1);
    mode = 2'd0;
    beat("t1", tu1, '0);
    check("t1_tx", tx, tu1);
    check("t1_sat", sat_event, 0);
    tick();
    check("t1_vdrop", tx_valid, 0);

    // Complex gain 0.5+0.5j in bank 0 entry 5
    cfg_wr(10'd5, 32'h2000_2000);
    swap_idle();
    check("t2_bank", active_bank, 0);
    check("t2_cnt", swap_count, 2);
    beat("t2_dpd", tu2, {10'd5, 10'd5});
    check("t2_dpd_tx", tx, {lane(-1200, -800), lane(750, 250)});
    tick();
    check("t2_idle_hold", tx, {lane(-1200, -800), lane(750, 250)});
    mode = 2'd2;
    beat("t2_zero", tu2, {10'd5, 10'd5});
    check("t2_zero_tx", tx, 0);
    mode = 2'd1;
    beat("t2_byp", tu2, {10'd5, 10'd5});
    check("t2_byp_tx", tx, tu2);
    mode = 2'd3;
    beat("t2_hold", tu1, {10'd5, 10'd5});
    check("t2_hold_tx", tx, tu2);

    // Saturation with gain ~2.0 in bank 1 entry 0
    cfg_wr(10'd0, 32'h0000_7fff);
    swap_idle();
    check("t3_bank", active_bank, 1);
    mode = 2'd0;
    beat("t3_pos", tu3, '0);
    check("t3_pos_tx", tx, {lane(-32768, 0), lane(32767, 32767)});
    check("t3_pos_sat", sat_event, 1);
    tick();
    check("t3_sat_pulse", sat_event, 0);
    beat("t3_neg", tu4, '0);
    check("t3_neg_tx", tx, {lane(200, -200), lane(-32768, 0)});
    check("t3_neg_sat", sat_event, 1);
    mode = 2'd1;
    beat("t3_byp", tu3, '0);
    check("t3_byp_tx", tx, tu3);
    check("t3_byp_sat", sat_event, 0);

    // Swap forced by timeout with continuous traffic
    tu = tu1; tu_enable = 1'b1; cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    check("t4_pend0", swap_pending, 1);
    for (int i = 1; i < ST; i++) begin
      tick();
      check("t4_pend", swap_pending, 1);
    end
    check("t4_bank_pre", active_bank, 1);
    tick();
    check("t4_pend_end", swap_pending, 0);
    check("t4_bank", active_bank, 0);
    check("t4_cnt", swap_count, 4);

    // Swap on an idle cycle, with a second request ignored
    cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    tick();
    cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    tick();
    check("t4b_pend", swap_pending, 1);
    check("t4b_bank_pre", active_bank, 0);
    tu_enable = 1'b0;
    tick();
    check("t4b_pend_end", swap_pending, 0);
    check("t4b_bank", active_bank, 1);
    check("t4b_cnt", swap_count, 5);
    tick(); tick();
    check("t4b_cnt_once", swap_count, 5);
    check("t4b_no_repend", swap_pending, 0);

    // Shadow readback and write on the swap edge
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 10'd3; cfg_din = 32'hdead_beef;
    tick();
    cfg_rd("t5_raw", 10'd3, 32'hdead_beef);
    check("t5_dout_hold", cfg_dout, 32'hdead_beef);
    cfg_rd("t5_e5", 10'd5, 32'h2000_2000);
    cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    check("t5_pend", swap_pending, 1);
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 10'd3; cfg_din = 32'h0000_2000;
    tick();
    cfg_en = 1'b0; cfg_we = 1'b0;
    check("t5_bank", active_bank, 0);
    check("t5_cnt", swap_count, 6);
    cfg_rd("t5_newshadow", 10'd3, 32'h0000_4000);
    mode = 2'd0;
    beat("t5_dp", tu5, {10'd5, 10'd3});
    check("t5_dp_tx", tx, {lane(750, 250), lane(500, -250)});

    // Reset with a pending swap and a full pipeline
    mode = 2'd1; tu = tu1; tu_enable = 1'b1; cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
    tick(); tick(); tick();
    check("t6_pend_pre", swap_pending, 1);
    check("t6_txv_pre", tx_valid, 1);
    rst_n = 1'b0; tu_enable = 1'b0;
    tick();
    check("t6_tx", tx, 0);
    check("t6_txv", tx_valid, 0);
    check("t6_dout", cfg_dout, 0);
    check("t6_cfgv", cfg_valid, 0);
    check("t6_bank", active_bank, 0);
    check("t6_cnt", swap_count, 0);
    check("t6_pend", swap_pending, 0);
    check("t6_sat", sat_event, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_txv", tx_valid, 0);
    end
    cfg_rd("t6_b1e0", 10'd0, 32'h0000_7fff);
    swap_idle();
    check("t6_cnt1", swap_count, 1);
    cfg_rd("t6_b0e3", 10'd3, 32'h0000_2000);
    cfg_rd("t6_b0e5", 10'd5, 32'h2000_2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
